// File: rtl/maxnet_stream_loader.sv
// Stream loader for the Maxnet core: fills X/W from a valid/ready word stream,
// kicks the controller, then returns the winner (or a timeout) on an output channel.

module maxnet_word_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);
    logic [DATA_W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)     q_q <= '0;
        else if (we_i) q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

module maxnet_stream_loader #(
    parameter int DATA_W  = 32,
    parameter int N       = 4,
    parameter int MAX_CYC = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_W-1:0]      in_data_i,
    output logic [N*DATA_W-1:0]    x_flat_o,
    output logic [N*N*DATA_W-1:0]  w_flat_o,
    output logic                   start_o,
    input  logic                   is_finished_i,
    input  logic [DATA_W-1:0]      res_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_W-1:0]      out_data_o,
    output logic                   out_err_o
);
    localparam int NW    = N * N;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int CYC_W = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_LOAD_X,
        S_LOAD_W,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } result_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    result_t             res_q, res_d;
    logic                accept;

    logic [N-1:0]                x_we;
    logic [NW-1:0]               w_we;
    logic [N-1:0][DATA_W-1:0]    x_q;
    logic [NW-1:0][DATA_W-1:0]   w_q;

    assign in_ready_o  = (state_q == S_LOAD_X) || (state_q == S_LOAD_W);
    assign accept      = in_valid_i && in_ready_o;
    assign start_o     = (state_q == S_START);
    assign out_valid_o = (state_q == S_OUT);
    assign out_data_o  = res_q.data;
    assign out_err_o   = res_q.err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_LOAD_X;
            idx_q   <= '0;
            cyc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        res_d   = res_q;
        case (state_q)
            S_LOAD_X: begin
                if (accept) begin
                    if (idx_q == IDX_W'(N - 1)) begin
                        idx_d   = '0;
                        state_d = S_LOAD_W;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_LOAD_W: begin
                if (accept) begin
                    if (idx_q == IDX_W'(NW - 1)) begin
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_START: begin
                cyc_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cyc_d = cyc_q + CYC_W'(1);
                // the completion flag can still be high from the previous job for two cycles
                if (is_finished_i && (cyc_q >= CYC_W'(2))) begin
                    res_d   = '{data: res_i, err: 1'b0};
                    state_d = S_OUT;
                end else if (cyc_q == CYC_W'(MAX_CYC)) begin
                    res_d   = '{data: '0, err: 1'b1};
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    idx_d   = '0;
                    state_d = S_LOAD_X;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = S_LOAD_X;
            end
        endcase
    end

    for (genvar k = 0; k < N; k++) begin : g_x
        assign x_we[k] = accept && (state_q == S_LOAD_X) && (idx_q == IDX_W'(k));
        maxnet_word_reg #(.DATA_W(DATA_W)) u_x (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .we_i  (x_we[k]),
            .d_i   (in_data_i),
            .q_o   (x_q[k])
        );
    end

    for (genvar k = 0; k < NW; k++) begin : g_w
        assign w_we[k] = accept && (state_q == S_LOAD_W) && (idx_q == IDX_W'(k));
        maxnet_word_reg #(.DATA_W(DATA_W)) u_w (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .we_i  (w_we[k]),
            .d_i   (in_data_i),
            .q_o   (w_q[k])
        );
    end

    assign x_flat_o = x_q;
    assign w_flat_o = w_q;
endmodule
